// File: rtl/audio_i2s_serializer.sv
// audio_i2s_serializer: stereo I2S / left-justified serializer for the board audio DAC.
// Latency: a pair accepted in frame N is shifted out in frame N+1 (left MSB 0 (LJ) or 1 (I2S) bck after ws falls).
// Backpressure: one-deep holding buffer; in_ready drops once it is full and reopens only at the next frame load.
// Optional build macro AUDIO_SER_MUTE_EN adds a 'mute' input, sampled at each frame load.
module audio_i2s_serializer #(
    parameter int DATA_W       = 16,
    parameter int SLOT_BITS    = 32,
    parameter int BCK_DIV_LOG2 = 2,
    parameter int I2S_MODE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
`ifdef AUDIO_SER_MUTE_EN
    input  logic              mute,
`endif
    output logic              in_ready,
    output logic              frame_start,
    output logic              underrun,
    output logic              audio_appsel,
    output logic              audio_sysclk,
    output logic              audio_bck,
    output logic              audio_ws,
    output logic              audio_data
);

    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int POS_W = $clog2(SLOT_BITS);
    localparam logic [POS_W:0] C_DATA_W = (POS_W + 1)'(DATA_W);

    logic [BCK_DIV_LOG2-1:0] r_div_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [DATA_W-1:0]       r_act_l;
    logic [DATA_W-1:0]       r_act_r;
    logic [DATA_W-1:0]       r_hold_l;
    logic [DATA_W-1:0]       r_hold_r;
    logic                    r_hold_vld;
    logic                    r_rdy_en;

    logic                    w_tick;
    logic                    w_frame_load;
    logic                    w_accept;
    logic                    w_lj_bit;
    logic                    w_mute_now;
    logic [POS_W-1:0]        w_pos;
    logic [DATA_W-1:0]       w_chan;
    logic [DATA_W-1:0]       w_shift;

    // tick = bck falling edge (divider wraps); frame load = tick that wraps the bit counter
    assign w_tick       = &r_div_cnt;
    assign w_frame_load = w_tick & (&r_bit_cnt);
    assign w_pos        = r_bit_cnt[POS_W-1:0];

    // r_rdy_en keeps in_ready low while in reset and until the first clock after release
    assign in_ready     = r_rdy_en & (~r_hold_vld | w_frame_load);
    assign w_accept     = in_valid & in_ready;

    assign frame_start  = w_frame_load;
    assign underrun     = w_frame_load & ~r_hold_vld;
    assign audio_appsel = 1'b1;
    assign audio_sysclk = clk;
    assign audio_bck    = r_div_cnt[BCK_DIV_LOG2-1];
    assign audio_ws     = r_bit_cnt[BIT_W-1];

`ifdef AUDIO_SER_MUTE_EN
    logic r_mute;

    // mute is latched only at frame load so a frame is either fully muted or not at all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mute <= 1'b0;
        end else if (w_frame_load) begin
            r_mute <= mute;
        end
    end

    assign w_mute_now = r_mute;
`else
    assign w_mute_now = 1'b0;
`endif

    // free-running bck divider, slot bit counter and post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_rdy_en  <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_rdy_en  <= 1'b1;
            if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // holding buffer and active frame; a load drains the buffer before a same-cycle accept refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_l    <= '0;
            r_act_r    <= '0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            if (w_frame_load && r_hold_vld) begin
                r_act_l <= r_hold_l;
                r_act_r <= r_hold_r;
            end
            if (w_accept) begin
                r_hold_l   <= in_left;
                r_hold_r   <= in_right;
                r_hold_vld <= 1'b1;
            end else if (w_frame_load) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    // left-justified bit for the current slot position: MSB first, zero padding past DATA_W
    always_comb begin
        w_chan   = r_bit_cnt[BIT_W-1] ? r_act_r : r_act_l;
        w_shift  = w_chan << w_pos;
        w_lj_bit = 1'b0;
        if (({1'b0, w_pos} < C_DATA_W) && !w_mute_now) begin
            w_lj_bit = w_shift[DATA_W-1];
        end
    end

    generate
        if (I2S_MODE != 0) begin : g_i2s
            logic r_dly;

            // one-bck delay: capture the bit of the slot position that is just ending
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= 1'b0;
                end else if (w_tick) begin
                    r_dly <= w_lj_bit;
                end
            end

            assign audio_data = r_dly;
        end else begin : g_lj
            assign audio_data = w_lj_bit;
        end
    endgenerate

endmodule
